skewed_acc_buffer: RTL

Parametrised, double-buffered operand accumulator that feeds the systolic array. It captures vectors of LANES values into one bank while the other bank drains. During a drain, lane i is delayed by i cycles so operands arrive diagonally at the array edge. It replaces separate per-operand accumulators with one block covering both weights and inputs, and adds forward/reverse drain order plus full/empty handshakes.

---
 rtl/skewed_acc_buffer_if.sv | 29 ++
 rtl/skewed_acc_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/skewed_acc_buffer_if.sv
// Write/drain bus for skewed_acc_buffer: vector capture handshake on one side,
// skewed per-lane operand stream towards the systolic array on the other.
interface skewed_acc_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int LANES      = 2
);
  logic                          wr_valid;
  logic                          wr_last;
  logic [LANES*DATA_WIDTH-1:0]   wr_data;
  logic                          wr_ready;
  logic [$clog2(DEPTH+1)-1:0]    wr_count;
  logic                          rd_start;
  logic                          rd_reverse;
  logic                          rd_ready;
  logic [LANES-1:0]              out_valid;
  logic [LANES*DATA_WIDTH-1:0]   out_data;
  logic                          rd_done;

  modport master (
    output wr_valid, wr_last, wr_data, rd_start, rd_reverse,
    input  wr_ready, wr_count, rd_ready, out_valid, out_data, rd_done
  );

  modport slave (
    input  wr_valid, wr_last, wr_data, rd_start, rd_reverse,
    output wr_ready, wr_count, rd_ready, out_valid, out_data, rd_done
  );
endinterface

// File: rtl/skewed_acc_buffer.sv
// Ping-pong operand buffer: one bank captures LANES-wide vectors while the other
// drains, with lane i delayed i cycles so operands enter the array diagonally.
module skewed_acc_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int LANES      = 2,
  parameter bit SKEW_EN    = 1'b1
) (
  input logic clk,
  input logic rst,
  skewed_acc_buffer_if.slave bus
);
  localparam int VEC_W     = LANES * DATA_WIDTH;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int FLUSH_CYC = SKEW_EN ? LANES - 1 : 0;
  localparam int FC_W      = $clog2(LANES + 1);
  localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYC);
  localparam logic [PTR_W-1:0] PTR_MAX    = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_SEALED, B_DRAINING} bank_state_e;
  typedef enum logic [1:0] {D_IDLE, D_STREAM, D_FLUSH} drain_state_e;

  logic [VEC_W-1:0] mem [2][DEPTH];

  bank_state_e      bank_state_reg [2];
  logic [CNT_W-1:0] bank_len_reg   [2];
  logic             wr_bank_reg;
  logic             rd_bank_reg;
  logic [PTR_W-1:0] wr_ptr_reg;

  drain_state_e     state_reg, state_next;
  logic [CNT_W-1:0] issued_reg;
  logic [CNT_W-1:0] len_reg;
  logic             rev_reg;
  logic [FC_W-1:0]  flush_cnt_reg;
  logic [VEC_W-1:0] base_data_reg;
  logic             base_valid_reg;

  logic             wr_ready;
  logic             rd_ready;
  logic             wr_accept;
  logic             wr_seal;
  logic             rd_accept;
  logic             issue_en;
  logic             rd_done;
  logic             sel_rev;
  logic [CNT_W-1:0] sel_len;
  logic [CNT_W-1:0] sel_k;
  logic [PTR_W-1:0] rd_idx;

  assign wr_ready  = (bank_state_reg[wr_bank_reg] == B_EMPTY) ||
                     (bank_state_reg[wr_bank_reg] == B_FILLING);
  assign rd_ready  = (bank_state_reg[rd_bank_reg] == B_SEALED) && (state_reg == D_IDLE);
  assign wr_accept = bus.wr_valid && wr_ready;
  assign wr_seal   = bus.wr_last || (wr_ptr_reg == PTR_MAX);

  assign bus.wr_ready = wr_ready;
  assign bus.wr_count = wr_ready ? CNT_W'(wr_ptr_reg) : '0;
  assign bus.rd_ready = rd_ready;
  assign bus.rd_done  = rd_done;

  // Bank bookkeeping: write and read events never target the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        bank_state_reg[b] <= B_EMPTY;
        bank_len_reg[b]   <= '0;
      end
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_ptr_reg  <= '0;
    end else begin
      if (wr_accept) begin
        if (wr_seal) begin
          bank_state_reg[wr_bank_reg] <= B_SEALED;
          bank_len_reg[wr_bank_reg]   <= CNT_W'(wr_ptr_reg) + CNT_W'(1);
          wr_bank_reg                 <= ~wr_bank_reg;
          wr_ptr_reg                  <= '0;
        end else begin
          bank_state_reg[wr_bank_reg] <= B_FILLING;
          wr_ptr_reg                  <= wr_ptr_reg + PTR_W'(1);
        end
      end
      if (rd_accept) begin
        bank_state_reg[rd_bank_reg] <= B_DRAINING;
      end
      if (rd_done) begin
        bank_state_reg[rd_bank_reg] <= B_EMPTY;
        rd_bank_reg                 <= ~rd_bank_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_accept  = 1'b0;
    issue_en   = 1'b0;
    rd_done    = 1'b0;
    case (state_reg)
      D_IDLE: begin
        if (bus.rd_start && rd_ready) begin
          rd_accept  = 1'b1;
          issue_en   = 1'b1;
          state_next = D_STREAM;
        end
      end
      D_STREAM: begin
        if (issued_reg != len_reg) begin
          issue_en = 1'b1;
        end else if (FLUSH_CYC == 0) begin
          rd_done    = 1'b1;
          state_next = D_IDLE;
        end else begin
          state_next = D_FLUSH;
        end
      end
      D_FLUSH: begin
        if (flush_cnt_reg == FLUSH_LAST) begin
          rd_done    = 1'b1;
          state_next = D_IDLE;
        end
      end
      default: state_next = D_IDLE;
    endcase
  end

  // The first element is addressed from the live request, later ones from latched state.
  always_comb begin
    sel_rev = (state_reg == D_IDLE) ? bus.rd_reverse : rev_reg;
    sel_len = (state_reg == D_IDLE) ? bank_len_reg[rd_bank_reg] : len_reg;
    sel_k   = (state_reg == D_IDLE) ? '0 : issued_reg;
    rd_idx  = PTR_W'(sel_rev ? (sel_len - sel_k - CNT_W'(1)) : sel_k);
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_bank_reg][wr_ptr_reg] <= bus.wr_data;
    end
    if (issue_en) begin
      base_data_reg <= mem[rd_bank_reg][rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= D_IDLE;
      base_valid_reg <= 1'b0;
      issued_reg     <= '0;
      len_reg        <= '0;
      rev_reg        <= 1'b0;
      flush_cnt_reg  <= FC_W'(1);
    end else begin
      state_reg      <= state_next;
      base_valid_reg <= issue_en;
      if (rd_accept) begin
        len_reg    <= bank_len_reg[rd_bank_reg];
        rev_reg    <= bus.rd_reverse;
        issued_reg <= CNT_W'(1);
      end else if (issue_en) begin
        issued_reg <= issued_reg + CNT_W'(1);
      end
      flush_cnt_reg <= (state_reg == D_FLUSH) ? flush_cnt_reg + FC_W'(1) : FC_W'(1);
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int LAT = SKEW_EN ? gi : 0;
    logic [DATA_WIDTH-1:0] lane_data;
    logic                  lane_valid;

    if (LAT == 0) begin : g_direct
      assign lane_data  = base_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign lane_valid = base_valid_reg;
    end else begin : g_skew
      logic [DATA_WIDTH-1:0] dly_data_reg [LAT];
      logic [LAT-1:0]        dly_valid_reg;

      // Only the valid bits need clearing; data is masked at the output.
      always_ff @(posedge clk) begin
        dly_data_reg[0] <= base_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 1; j < LAT; j++) begin
          dly_data_reg[j] <= dly_data_reg[j-1];
        end
        if (rst) begin
          dly_valid_reg <= '0;
        end else begin
          dly_valid_reg <= LAT'({dly_valid_reg, base_valid_reg});
        end
      end

      assign lane_data  = dly_data_reg[LAT-1];
      assign lane_valid = dly_valid_reg[LAT-1];
    end

    assign bus.out_valid[gi]                            = lane_valid;
    assign bus.out_data[gi*DATA_WIDTH +: DATA_WIDTH]     = lane_valid ? lane_data : '0;
  end
endmodule
